// File: rtl/fp_align_stage.sv
// FP32 adder operand-alignment stage: hidden-bit restore, magnitude ordering,
// and right shift of the smaller mantissa with guard/round/sticky, in a 2-deep valid/ready pipe.
module fp_align_stage #(
  parameter int EXP_W     = 8,
  parameter int MAN_W     = 23,
  parameter int SHIFT_SAT = 27
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               signA,
  input  logic               signB,
  input  logic [EXP_W-1:0]   exponentA,
  input  logic [EXP_W-1:0]   exponentB,
  input  logic [MAN_W-1:0]   mantissaA,
  input  logic [MAN_W-1:0]   mantissaB,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sign_big,
  output logic               sign_small,
  output logic [EXP_W-1:0]   exp_out,
  output logic [MAN_W:0]     mant_big,
  output logic [MAN_W:0]     mant_small,
  output logic [2:0]         grs,
  output logic               eff_sub,
  output logic               special
);

  localparam int SIG_W = MAN_W + 1;
  localparam int EXT_W = SIG_W + 3;
  localparam logic [EXP_W-1:0] SAT_E = EXP_W'(SHIFT_SAT);

  logic               s1_valid;
  logic               s1_sign_big;
  logic               s1_sign_small;
  logic [EXP_W-1:0]   s1_exp;
  logic [SIG_W-1:0]   s1_mant_big;
  logic [SIG_W-1:0]   s1_mant_small;
  logic [EXP_W-1:0]   s1_diff;
  logic               s1_special;

  logic               s2_load;
  logic               s1_advance;
  logic               in_fire;

  assign s2_load    = !out_valid || out_ready;
  assign s1_advance = s1_valid && s2_load;
  assign in_ready   = !s1_valid || s1_advance;
  assign in_fire    = in_valid && in_ready;

  // S1: denormals use an effective exponent of 1 and a cleared hidden bit
  logic               hid_a;
  logic               hid_b;
  logic [EXP_W-1:0]   eff_a;
  logic [EXP_W-1:0]   eff_b;
  logic [SIG_W-1:0]   sig_a;
  logic [SIG_W-1:0]   sig_b;
  logic               a_big;

  always_comb begin
    hid_a = |exponentA;
    hid_b = |exponentB;
    eff_a = hid_a ? exponentA : EXP_W'(1);
    eff_b = hid_b ? exponentB : EXP_W'(1);
    sig_a = {hid_a, mantissaA};
    sig_b = {hid_b, mantissaB};
    a_big = {eff_a, sig_a} >= {eff_b, sig_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_sign_big   <= 1'b0;
      s1_sign_small <= 1'b0;
      s1_exp        <= '0;
      s1_mant_big   <= '0;
      s1_mant_small <= '0;
      s1_diff       <= '0;
      s1_special    <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_fire) begin
        s1_sign_big   <= a_big ? signA : signB;
        s1_sign_small <= a_big ? signB : signA;
        s1_exp        <= a_big ? eff_a : eff_b;
        s1_mant_big   <= a_big ? sig_a : sig_b;
        s1_mant_small <= a_big ? sig_b : sig_a;
        s1_diff       <= a_big ? (eff_a - eff_b) : (eff_b - eff_a);
        s1_special    <= (&exponentA) || (&exponentB);
      end
    end
  end

  // S2: alignment shift; bits falling off the bottom fold into sticky
  logic [EXT_W-1:0]   ext;
  logic [EXT_W-1:0]   lost_mask;
  logic [EXT_W-1:0]   shifted;
  logic [SIG_W-1:0]   sh_mant;
  logic [2:0]         sh_grs;

  always_comb begin
    ext       = {s1_mant_small, 3'b000};
    lost_mask = '0;
    shifted   = '0;
    sh_mant   = '0;
    sh_grs    = '0;
    if (s1_diff >= SAT_E) begin
      sh_grs = {2'b00, |s1_mant_small};
    end else begin
      lost_mask = ~({EXT_W{1'b1}} << s1_diff);
      shifted   = ext >> s1_diff;
      sh_mant   = shifted[EXT_W-1:3];
      sh_grs    = {shifted[2:1], shifted[0] | (|(ext & lost_mask))};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      sign_big   <= 1'b0;
      sign_small <= 1'b0;
      exp_out    <= '0;
      mant_big   <= '0;
      mant_small <= '0;
      grs        <= '0;
      eff_sub    <= 1'b0;
      special    <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sign_big   <= s1_sign_big;
        sign_small <= s1_sign_small;
        exp_out    <= s1_exp;
        mant_big   <= s1_mant_big;
        mant_small <= sh_mant;
        grs        <= sh_grs;
        eff_sub    <= s1_sign_big ^ s1_sign_small;
        special    <= s1_special;
      end
    end
  end

endmodule

// File: tb/tb_fp_align_stage.sv
// Bench for fp_align_stage: directed vector table, multi-cycle stall/reset
// sequences, and random traffic scored against an arithmetic reference model.
module tb_fp_align_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        signA = 1'b0, signB = 1'b0;
  logic [7:0]  exponentA = '0, exponentB = '0;
  logic [22:0] mantissaA = '0, mantissaB = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        sign_big, sign_small;
  logic [7:0]  exp_out;
  logic [23:0] mant_big, mant_small;
  logic [2:0]  grs;
  logic        eff_sub, special;

  fp_align_stage #(.EXP_W(8), .MAN_W(23), .SHIFT_SAT(27)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .signA(signA), .signB(signB), .exponentA(exponentA), .exponentB(exponentB),
    .mantissaA(mantissaA), .mantissaB(mantissaB), .out_valid(out_valid),
    .out_ready(out_ready), .sign_big(sign_big), .sign_small(sign_small),
    .exp_out(exp_out), .mant_big(mant_big), .mant_small(mant_small), .grs(grs),
    .eff_sub(eff_sub), .special(special)
  );

  always #5 clk = ~clk;

  logic [62:0] out_vec;
  assign out_vec = {sign_big, sign_small, exp_out, mant_big, mant_small, grs, eff_sub, special};

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [62:0] pack(input logic sb, input logic ss, input logic [7:0] e,
                                       input logic [23:0] mb, input logic [23:0] ms,
                                       input logic [2:0] g, input logic sp);
    return {sb, ss, e, mb, ms, g, sb ^ ss, sp};
  endfunction

  // Reference: order by true magnitude, then divide the 27-bit extended
  // mantissa by 2^diff and note any nonzero remainder as sticky.
  function automatic logic [62:0] ref_model(input logic sa, input logic [7:0] ea, input logic [22:0] ma,
                                            input logic sb, input logic [7:0] eb, input logic [22:0] mb);
    longint sig_a, sig_b, eff_a, eff_b, key_a, key_b;
    longint s_big, s_small, e_big, e_small, d, ext, q, pw;
    logic lost, g_big, g_small;
    logic [2:0] g3;
    sig_a = (ea != 0 ? 64'(1) << 23 : 0) + longint'(ma);
    sig_b = (eb != 0 ? 64'(1) << 23 : 0) + longint'(mb);
    eff_a = (ea == 0) ? 1 : longint'(ea);
    eff_b = (eb == 0) ? 1 : longint'(eb);
    key_a = eff_a * (64'(1) << 24) + sig_a;
    key_b = eff_b * (64'(1) << 24) + sig_b;
    if (key_a >= key_b) begin
      s_big = sig_a; s_small = sig_b; e_big = eff_a; e_small = eff_b; g_big = sa; g_small = sb;
    end else begin
      s_big = sig_b; s_small = sig_a; e_big = eff_b; e_small = eff_a; g_big = sb; g_small = sa;
    end
    d = e_big - e_small;
    ext = s_small * 8;
    if (d >= 27) begin
      q = 0;
      lost = (ext != 0);
    end else begin
      pw = 64'(1) << d;
      q = ext / pw;
      lost = (q * pw != ext);
    end
    g3 = 3'(q % 8);
    g3[0] = g3[0] | lost;
    return pack(g_big, g_small, 8'(e_big), 24'(s_big), 24'(q / 8), g3,
                (ea == 8'hFF) || (eb == 8'hFF));
  endfunction

  // Scoreboard and per-cycle handshake bookkeeping
  logic [62:0] q_exp[$];
  logic [62:0] pending_exp = '0;
  int          inflight = 0;
  int          drained = 0;
  logic        stall_prev = 1'b0;
  logic [62:0] snap = '0;

  task automatic step(output logic acc);
    logic drn;
    @(negedge clk);
    chk("in_ready", 64'(in_ready), 64'(!(inflight == 2 && !out_ready)));
    if (stall_prev) chk("stall_hold", {out_valid, out_vec}, {1'b1, snap});
    drn = out_valid && out_ready;
    acc = in_valid && in_ready;
    if (drn) begin
      drained++;
      if (q_exp.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out: got %h expected no output", out_vec);
      end else begin
        chk("result", 64'(out_vec), 64'(q_exp.pop_front()));
      end
    end
    if (acc) q_exp.push_back(pending_exp);
    stall_prev = out_valid && !out_ready;
    snap = out_vec;
    inflight = inflight + int'(acc) - int'(drn);
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic sa, input logic [7:0] ea, input logic [22:0] ma,
                         input logic sb, input logic [7:0] eb, input logic [22:0] mb);
    signA = sa; exponentA = ea; mantissaA = ma;
    signB = sb; exponentB = eb; mantissaB = mb;
  endtask

  // Single isolated transfer with an explicit two-cycle latency check
  task automatic run_one(input logic [62:0] expv);
    logic acc;
    out_ready = 1'b1;
    in_valid = 1'b1;
    pending_exp = expv;
    step(acc);
    chk("accept", 64'(acc), 64'(1));
    in_valid = 1'b0;
    chk("lat_early", 64'(out_valid), 64'(0));
    step(acc);
    chk("latency", 64'(out_valid), 64'(1));
    step(acc);
  endtask

  task automatic gen_random();
    int t;
    logic [7:0] ea, eb;
    ea = 8'($urandom_range(0, 255));
    case ($urandom % 4)
      0: eb = 8'($urandom_range(0, 255));
      1: begin
        t = int'(ea) + int'($urandom_range(0, 30)) - 15;
        if (t < 0) t = 0;
        if (t > 255) t = 255;
        eb = 8'(t);
      end
      2: eb = ea;
      default: eb = 8'($urandom_range(0, 2));
    endcase
    set_ops(1'($urandom), ea, 23'($urandom), 1'($urandom), eb, 23'($urandom));
    pending_exp = ref_model(signA, exponentA, mantissaA, signB, exponentB, mantissaB);
  endtask

  typedef struct {
    string       name;
    logic        sa;
    logic [7:0]  ea;
    logic [22:0] ma;
    logic        sb;
    logic [7:0]  eb;
    logic [22:0] mb;
    logic [62:0] expv;
  } vec_t;

  function automatic vec_t mk(input string n, input logic sa, input logic [7:0] ea, input logic [22:0] ma,
                              input logic sb, input logic [7:0] eb, input logic [22:0] mb,
                              input logic [62:0] expv);
    vec_t v;
    v.name = n; v.sa = sa; v.ea = ea; v.ma = ma; v.sb = sb; v.eb = eb; v.mb = mb; v.expv = expv;
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
    logic acc;
    int   c, issued, d0;
    logic pat[4];

    tbl[0]  = mk("one_plus_one", 0, 127, 0, 0, 127, 0, pack(0, 0, 127, 24'h800000, 24'h800000, 3'b000, 0));
    tbl[1]  = mk("diff24",       0, 127, 0, 0, 103, 0, pack(0, 0, 127, 24'h800000, 24'h000000, 3'b100, 0));
    tbl[2]  = mk("diff30",       0, 127, 0, 0,  97, 0, pack(0, 0, 127, 24'h800000, 24'h000000, 3'b001, 0));
    tbl[3]  = mk("swap",         1, 127, 23'h400000, 0, 128, 23'h400000,
                 pack(0, 1, 128, 24'hC00000, 24'h600000, 3'b000, 0));
    tbl[4]  = mk("tie_a_big",    1, 130, 23'h123456, 0, 130, 23'h123456,
                 pack(1, 0, 130, 24'h923456, 24'h923456, 3'b000, 0));
    tbl[5]  = mk("denorm",       0, 0, 23'h000001, 0, 1, 0, pack(0, 0, 1, 24'h800000, 24'h000001, 3'b000, 0));
    tbl[6]  = mk("special_a",    0, 255, 0, 0, 127, 0, pack(0, 0, 255, 24'h800000, 24'h000000, 3'b001, 1));
    tbl[7]  = mk("diff4_sticky", 0, 130, 0, 1, 126, 23'h7FFFFF, pack(0, 1, 130, 24'h800000, 24'h0FFFFF, 3'b111, 0));
    tbl[8]  = mk("diff25",       0, 152, 0, 0, 127, 23'h000001, pack(0, 0, 152, 24'h800000, 24'h000000, 3'b011, 0));
    tbl[9]  = mk("diff27_sat",   0, 154, 0, 0, 127, 0, pack(0, 0, 154, 24'h800000, 24'h000000, 3'b001, 0));
    tbl[10] = mk("both_denorm",  0, 0, 23'h000005, 1, 0, 23'h000003, pack(0, 1, 1, 24'h000005, 24'h000003, 3'b000, 0));
    tbl[11] = mk("special_b",    1, 3, 23'h000010, 0, 255, 23'h000001, pack(0, 1, 255, 24'h800001, 24'h000000, 3'b001, 1));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_vec), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));

    // Directed table
    foreach (tbl[i]) begin
      set_ops(tbl[i].sa, tbl[i].ea, tbl[i].ma, tbl[i].sb, tbl[i].eb, tbl[i].mb);
      run_one(tbl[i].expv);
    end
    chk("table_drained", 64'(q_exp.size()), 64'(0));

    // Eight back-to-back pairs against an out_ready pattern 1,0,0,1
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    d0 = drained;
    issued = 0;
    c = 0;
    acc = 1'b0;
    while ((issued < 8 || q_exp.size() != 0) && c < 100) begin
      out_ready = pat[c % 4];
      if (issued < 8) begin
        gen_random();
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step(acc);
      if (acc) issued++;
      c++;
    end
    in_valid = 1'b0;
    chk("stream_count", 64'(drained - d0), 64'(8));
    chk("stream_empty", 64'(q_exp.size()), 64'(0));

    // Reset with two pairs in flight
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      gen_random();
      in_valid = 1'b1;
      step(acc);
    end
    in_valid = 1'b0;
    chk("two_in_flight", 64'(inflight), 64'(2));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_data", 64'(out_vec), 64'(0));
    q_exp.delete();
    inflight = 0;
    stall_prev = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    set_ops(0, 127, 0, 0, 127, 0);
    run_one(pack(0, 0, 127, 24'h800000, 24'h800000, 3'b000, 0));
    chk("post_rst_empty", 64'(q_exp.size()), 64'(0));

    // Random traffic with random back-pressure
    acc = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!in_valid || acc) begin
        gen_random();
        in_valid = ($urandom % 4) != 0;
      end
      out_ready = ($urandom % 3) != 0;
      step(acc);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    c = 0;
    while (q_exp.size() != 0 && c < 10) begin
      step(acc);
      c++;
    end
    chk("random_drained", 64'(q_exp.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
